// File: rtl/mul_seq.sv
// Sequential unsigned shift-and-add multiplier that reuses add_sub.
// Ports: clk, rst, start, a, b -> busy, done, p (2*WIRE-bit product).

module add_sub #(
   parameter int WIRE = 8
) (
   input  logic [WIRE-1:0] a,
   input  logic [WIRE-1:0] b,
   input  logic            sub,
   input  logic            cin,
   output logic [WIRE-1:0] s,
   output logic            cout
);

   logic [WIRE-1:0] bx;

   assign bx = sub ? ~b : b;
   assign {cout, s} = {1'b0, a} + {1'b0, bx}
                    + {{WIRE{1'b0}}, cin};

endmodule

module mul_seq #(
   parameter int WIRE = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIRE-1:0]   a,
   input  logic [WIRE-1:0]   b,
   output logic              busy,
   output logic              done,
   output logic [2*WIRE-1:0] p
);

   localparam int CW = (WIRE > 2) ? $clog2(WIRE) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIRE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIRE-1:0]   mcand_q, mcand_d;
   logic [WIRE-1:0]   acc_q, acc_d;
   logic [WIRE-1:0]   low_q, low_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*WIRE-1:0] p_q, p_d;

   logic [WIRE-1:0]   add_b;
   logic [WIRE-1:0]   sum;
   logic              carry;
   logic [2*WIRE-1:0] shifted;

   // Multiplicand is added only when the current multiplier bit is set.
   assign add_b = low_q[0] ? mcand_q : '0;

   add_sub #(.WIRE(WIRE)) u_add (
      .a    (acc_q),
      .b    (add_b),
      .sub  (1'b0),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry)
   );

   // Full (WIRE+1)-bit sum shifts right together with the multiplier bits,
   // so the carry lands in the top of acc and is never lost.
   assign shifted = {carry, sum, low_q[WIRE-1:1]};

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      low_d   = low_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d = a;
               low_d   = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            {acc_d, low_d} = shifted;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               p_d     = shifted;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         acc_q   <= '0;
         low_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         low_q   <= low_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign p    = p_q;

endmodule
